// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO reader engine.
// The read limit keeps the buffered plus in-flight words within the skid buffer.
package fifo_rd_pkg;

  localparam int RD_LATENCY = 1;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // Issue a read only if the words held after this cycle leave room for the read latency.
  localparam logic [2:0] RD_LIMIT = 3'(SKID_DEPTH - RD_LATENCY);

  function automatic logic [2:0] occ_after(input occ_t count, input logic inflight,
                                           input logic pop);
    return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; the head is always presented on dout.
// Push and pop in the same cycle keep the occupancy unchanged.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output occ_t                  count
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  occ_t                  count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = din;
        else                 tail_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // With one word held the new word becomes the head directly.
        if (count_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO with one-cycle read latency onto a valid/ready stream.
// Reads are throttled so that buffered plus in-flight words never exceed the skid buffer.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  output logic                  cs,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  full,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  drain_count,
  output logic                  idle
);

  logic                 inflight_q;
  logic [CNT_WIDTH-1:0] drain_q, drain_d;
  occ_t                 count;
  logic                 pop;
  logic                 unused_full;

  assign unused_full = full;

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk  (clk),
    .reset(reset),
    .push (inflight_q),
    .din  (data_out),
    .pop  (pop),
    .dout (m_data),
    .count(count)
  );

  assign m_valid = (count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign cs      = en;
  // m_ready reaches rd_en combinationally so a pop frees room in the same cycle.
  assign rd_en   = !reset && en && !empty && (occ_after(count, inflight_q, pop) <= RD_LIMIT);

  assign drain_d = pop ? drain_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : drain_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      drain_q    <= '0;
    end else begin
      inflight_q <= rd_en;
      drain_q    <= drain_d;
    end
  end

  assign drain_count = drain_q;
  assign idle        = (count == 2'd0) && !inflight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a word-array FIFO model feeds the reader and a
// scoreboard checks every delivered word against write order, counters and status.
module tb_fifo_stream_reader;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int MEMN = 4096;

  logic          clk = 1'b0;
  logic          reset, en, cs, rd_en, empty, full, m_valid, m_ready, idle;
  logic [DW-1:0] data_out, m_data;
  logic [CW-1:0] drain_count;
  logic          force_empty;

  logic [DW-1:0] mem [MEMN];
  int            wr_ptr, rd_ptr, reads, pops, exp_idx, tests, fails;
  logic          prev_valid, prev_pop;
  logic [DW-1:0] prev_data;

  always #5 clk = ~clk;

  assign empty = (wr_ptr == rd_ptr) || force_empty;
  assign full  = (wr_ptr - rd_ptr) >= 16;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cs         (cs),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .empty      (empty),
    .full       (full),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .drain_count(drain_count),
    .idle       (idle)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model: one-cycle read latency, words taken in write order.
  always @(posedge clk) begin
    if (reset) begin
      reads <= 0;
    end else if (rd_en) begin
      data_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
      reads    <= reads + 1;
    end
  end

  // Scoreboard: words read but not yet delivered are the only thing that can be held.
  always @(negedge clk) begin
    if (reset) begin
      pops       = 0;
      exp_idx    = rd_ptr;
      prev_valid = 1'b0;
      prev_pop   = 1'b0;
    end else begin
      chk("rd_while_empty", rd_en && empty, 1'b0);
      chk("cs_follows_en", cs, en);
      chk("count_le2", dut.u_skid.count <= 2'd2, 1'b1);
      chk("drain_count", drain_count, pops[CW-1:0]);
      chk("idle", idle, (reads - pops) == 0);
      if (prev_valid && !prev_pop) begin
        chk("valid_hold", m_valid, 1'b1);
        chk("data_hold", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        chk("stream_order", m_data, mem[exp_idx]);
        exp_idx++;
        pops++;
      end
      prev_valid = m_valid;
      prev_pop   = m_valid && m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    if (wr_ptr < MEMN) begin
      mem[wr_ptr] = w;
      wr_ptr++;
    end
  endtask

  task automatic drain();
    int n = 0;
    en = 1'b1; m_ready = 1'b1; force_empty = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!((wr_ptr == rd_ptr) && idle) && n < 200);
    chk("drain_done", (wr_ptr == rd_ptr) && idle, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    drain();
    en = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]    rdv, mv;
    logic [DW-1:0] md [6];
    int            n, start;

    tests = 0; fails = 0; wr_ptr = 0;
    en = 1'b0; m_ready = 1'b0; force_empty = 1'b0; reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_drain", drain_count, '0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_rd_en", rd_en, 1'b0);

    // Three preloaded words, continuous ready.
    tick();
    reset = 1'b0;
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdv[i] = rd_en;
      mv[i]  = m_valid;
      md[i]  = m_data;
    end
    chk("t1_rd_pattern", rdv, 6'b000111);
    chk("t1_valid_pattern", mv, 6'b011100);
    chk("t1_word0", md[2], 32'h11);
    chk("t1_word1", md[3], 32'h22);
    chk("t1_word2", md[4], 32'h33);
    @(negedge clk);
    chk("t1_drain", drain_count, 4'd3);
    chk("t1_idle", idle, 1'b1);

    // Consumer stall with ten words queued.
    do_reset();
    for (int i = 0; i < 10; i++) push_word($urandom);
    en = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(rd_en);
    end
    chk("t2_rd_pulses", n, 2);
    chk("t2_count", dut.u_skid.count, 2'd2);
    chk("t2_rd_low", rd_en, 1'b0);
    tick();
    start = pops;
    m_ready = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(m_valid);
    end
    chk("t2_no_gaps", n, 10);
    tick(); tick();
    chk("t2_delivered", pops - start, 10);

    // en drops right after a single read is issued.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word($urandom);
    start = pops;
    en = 1'b1;
    @(negedge clk);
    chk("t3_rd_issued", rd_en, 1'b1);
    tick();
    en = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(rd_en);
    end
    chk("t3_no_more_rd", n, 0);
    tick();
    chk("t3_inflight_delivered", pops - start, 1);

    // empty toggling every cycle under continuous ready.
    do_reset();
    for (int i = 0; i < 12; i++) push_word($urandom);
    start = pops;
    en = 1'b1; m_ready = 1'b1;
    repeat (40) begin
      tick();
      force_empty = ~force_empty;
    end
    force_empty = 1'b0;
    tick();
    chk("t4_delivered", pops - start, 12);

    // Reset with a buffered word and one in flight.
    do_reset();
    for (int i = 0; i < 6; i++) push_word($urandom);
    en = 1'b1; m_ready = 1'b1;
    tick(); tick(); tick();
    m_ready = 1'b0;
    @(negedge clk);
    chk("t5_pre_drain", drain_count, 4'd1);
    chk("t5_pre_busy", idle, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_valid", m_valid, 1'b0);
    chk("t5_async_rd_en", rd_en, 1'b0);
    @(negedge clk);
    chk("t5_rst_valid", m_valid, 1'b0);
    chk("t5_rst_drain", drain_count, '0);
    chk("t5_rst_idle", idle, 1'b1);
    tick();
    reset = 1'b0;

    // Counter wraps in the 4-bit build.
    do_reset();
    for (int i = 0; i < 17; i++) push_word($urandom);
    en = 1'b1; m_ready = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    chk("t6_wrap", drain_count, 4'd1);
    chk("t6_delivered", pops, 17);

    // Randomised traffic.
    do_reset();
    repeat (1500) begin
      tick();
      en          = ($urandom_range(0, 9) != 0);
      m_ready     = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) push_word($urandom);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
